// File: rtl/irq_arbiter_pkg.sv
// Shared constants, code map and FSM encoding for the interrupt arbiter.
package irq_arbiter_pkg;

  localparam int NUM_SRC_DEF  = 3;
  localparam int HOLD_CYC_DEF = 2;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_SRC0 = 2'b01;
  localparam logic [1:0] CODE_SRC1 = 2'b10;
  localparam logic [1:0] CODE_SRC2 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  // Source index to break code: index 0 maps to 2'b01, code 2'b00 means none.
  function automatic logic [1:0] src_code(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/irq_arbiter_prio_enc.sv
// Fixed-priority encoder: reports the highest set bit of req and whether any bit is set.
module irq_prio_enc
  import irq_arbiter_pkg::*;
#(
  parameter int WIDTH = NUM_SRC_DEF
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [1:0]       idx
);

  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 2'(i);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Nested interrupt arbiter: edge-captured pending bits, in-service tracking,
// one-cycle break pulse followed by a lock-out window.
//
//   state    | meaning
//   ST_IDLE  | waiting for an eligible candidate
//   ST_ISSUE | out_BK/out_code presented for one cycle
//   ST_HOLD  | lock-out, HOLD_CYC cycles, no new issue
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int NUM_SRC  = NUM_SRC_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic               in_CLK,
  input  logic               in_RST,
  input  logic [NUM_SRC-1:0] in_irq,
  input  logic [NUM_SRC-1:0] in_mask,
  input  logic               in_IE,
  input  logic               in_eret,
  output logic               out_BK,
  output logic [1:0]         out_code,
  output logic [NUM_SRC-1:0] out_pend,
  output logic [NUM_SRC-1:0] out_isr,
  output logic               out_busy
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic [NUM_SRC-1:0] irq_hist_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] isr_q, isr_d;
  logic [NUM_SRC-1:0] edge_det;
  logic               bk_q;
  logic [1:0]         code_q;
  logic               cand_valid, isr_valid;
  logic [1:0]         cand_idx, isr_idx;
  logic               issue;

  irq_prio_enc #(.WIDTH(NUM_SRC)) u_cand_enc (
    .req   (pend_q & in_mask),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  irq_prio_enc #(.WIDTH(NUM_SRC)) u_isr_enc (
    .req   (isr_q),
    .valid (isr_valid),
    .idx   (isr_idx)
  );

  // State register with lock-out down-counter
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ISSUE)
        hold_cnt_q <= HOLD_LOAD;
      else if (state_q == ST_HOLD && hold_cnt_q != '0)
        hold_cnt_q <= hold_cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (issue) state_d = ST_ISSUE;
      ST_ISSUE: state_d = (HOLD_CYC > 0) ? ST_HOLD : ST_IDLE;
      ST_HOLD:  if (hold_cnt_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/decision logic; a returning handler blocks issue for this cycle
  always_comb begin
    issue = (state_q == ST_IDLE) && in_IE && !in_eret && cand_valid &&
            (!isr_valid || (cand_idx > isr_idx));
    out_busy = (state_q != ST_IDLE);
  end

  always_comb begin
    edge_det = in_irq & ~irq_hist_q;

    pend_d = pend_q;
    if (issue) pend_d[cand_idx] = 1'b0;
    pend_d = pend_d | edge_det;

    isr_d = isr_q;
    if (in_eret && isr_valid) isr_d[isr_idx] = 1'b0;
    if (issue) isr_d[cand_idx] = 1'b1;
  end

  // History reloads from the live lines on reset so held-high lines never count as edges
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      irq_hist_q <= in_irq;
      pend_q     <= '0;
      isr_q      <= '0;
      bk_q       <= 1'b0;
      code_q     <= CODE_NONE;
    end else begin
      irq_hist_q <= in_irq;
      pend_q     <= pend_d;
      isr_q      <= isr_d;
      bk_q       <= issue;
      code_q     <= issue ? src_code(cand_idx) : CODE_NONE;
    end
  end

  assign out_BK   = bk_q;
  assign out_code = code_q;
  assign out_pend = pend_q;
  assign out_isr  = isr_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: directed scenarios queue expected breaks,
// a negedge monitor pops and compares every out_BK pulse.
module tb_irq_arbiter;

  logic       in_CLK;
  logic       in_RST;
  logic [2:0] in_irq;
  logic [2:0] in_mask;
  logic       in_IE;
  logic       in_eret;
  logic       out_BK;
  logic [1:0] out_code;
  logic [2:0] out_pend;
  logic [2:0] out_isr;
  logic       out_busy;

  typedef struct {
    logic [1:0] code;
    logic [2:0] isr;
    logic [2:0] pend;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  irq_arbiter #(.NUM_SRC(3), .HOLD_CYC(2)) dut (
    .in_CLK   (in_CLK),
    .in_RST   (in_RST),
    .in_irq   (in_irq),
    .in_mask  (in_mask),
    .in_IE    (in_IE),
    .in_eret  (in_eret),
    .out_BK   (out_BK),
    .out_code (out_code),
    .out_pend (out_pend),
    .out_isr  (out_isr),
    .out_busy (out_busy)
  );

  initial in_CLK = 1'b0;
  always #5 in_CLK = ~in_CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge in_CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic expect_bk(input logic [1:0] code, input logic [2:0] isr, input logic [2:0] pend);
    exp_t e;
    e.code = code;
    e.isr  = isr;
    e.pend = pend;
    sb.push_back(e);
  endtask

  task automatic eret_pulse();
    in_eret = 1'b1;
    step(1);
    in_eret = 1'b0;
  endtask

  always @(negedge in_CLK) begin
    if (!in_RST && out_BK) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_bk: got code=%b isr=%b pend=%b, want no break", out_code, out_isr, out_pend);
      end else begin
        mon_e = sb.pop_front();
        if (out_code !== mon_e.code || out_isr !== mon_e.isr || out_pend !== mon_e.pend) begin
          n_errors++;
          $display("FAIL bk_issue: got code=%b isr=%b pend=%b, want code=%b isr=%b pend=%b",
                   out_code, out_isr, out_pend, mon_e.code, mon_e.isr, mon_e.pend);
        end
      end
    end
  end

  initial begin
    int busy_cnt;
    int bk_cnt;
    in_RST  = 1'b1;
    in_irq  = 3'b000;
    in_mask = 3'b000;
    in_IE   = 1'b0;
    in_eret = 1'b0;
    step(2);
    check("rst_bk",   out_BK,   1'b0);
    check("rst_code", out_code, 2'b00);
    check("rst_pend", out_pend, 3'b000);
    check("rst_isr",  out_isr,  3'b000);
    check("rst_busy", out_busy, 1'b0);
    in_RST = 1'b0;
    step(1);

    // Single source issue and busy window
    in_mask = 3'b111;
    in_IE   = 1'b1;
    expect_bk(2'b01, 3'b001, 3'b000);
    in_irq  = 3'b001;
    busy_cnt = 0;
    bk_cnt   = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (out_busy) busy_cnt++;
      if (out_BK) bk_cnt++;
    end
    check("t1_busy_cycles", busy_cnt, 3);
    check("t1_bk_cycles",   bk_cnt,   1);
    check("t1_level_no_repend", out_pend, 3'b000);
    check("t1_isr", out_isr, 3'b001);

    // Preemption by source 2, source 1 waits for eret
    expect_bk(2'b11, 3'b101, 3'b000);
    in_irq = 3'b101;
    step(8);
    check("t2_isr_preempt", out_isr, 3'b101);
    in_irq = 3'b111;
    step(6);
    check("t2_pend_wait", out_pend, 3'b010);
    check("t2_isr_wait",  out_isr,  3'b101);
    expect_bk(2'b10, 3'b011, 3'b000);
    eret_pulse();
    check("t2_isr_after_eret", out_isr, 3'b001);
    check("t2_no_bk_on_eret",  out_BK,  1'b0);
    step(6);
    check("t2_isr_nested", out_isr, 3'b011);
    eret_pulse();
    eret_pulse();
    check("t2_isr_clear", out_isr, 3'b000);
    in_irq = 3'b000;
    step(2);

    // Simultaneous edges: strict priority order across erets
    expect_bk(2'b11, 3'b100, 3'b011);
    in_irq = 3'b111;
    step(8);
    check("t3_pend", out_pend, 3'b011);
    check("t3_isr",  out_isr,  3'b100);
    expect_bk(2'b10, 3'b010, 3'b001);
    eret_pulse();
    step(8);
    check("t3_isr_src1", out_isr, 3'b010);
    expect_bk(2'b01, 3'b001, 3'b000);
    eret_pulse();
    step(8);
    check("t3_isr_src0", out_isr, 3'b001);
    eret_pulse();
    check("t3_isr_clear", out_isr, 3'b000);
    in_irq = 3'b000;
    step(2);

    // Masked pending bit is retained, issues once unmasked
    in_mask = 3'b000;
    in_irq  = 3'b010;
    step(6);
    check("t4_masked_pend", out_pend, 3'b010);
    check("t4_masked_isr",  out_isr,  3'b000);
    expect_bk(2'b10, 3'b010, 3'b000);
    in_mask = 3'b010;
    step(6);
    check("t4_unmasked_isr", out_isr, 3'b010);
    eret_pulse();
    in_irq  = 3'b000;
    in_mask = 3'b111;
    step(2);

    // eret in the decision cycle delays issue by one cycle
    expect_bk(2'b01, 3'b001, 3'b000);
    in_irq = 3'b001;
    step(1);
    check("t5_pend", out_pend, 3'b001);
    in_eret = 1'b1;
    step(1);
    in_eret = 1'b0;
    check("t5_bk_suppressed", out_BK,  1'b0);
    check("t5_isr_eret_noop", out_isr, 3'b000);
    step(1);
    check("t5_bk_late",   out_BK,   1'b1);
    check("t5_code_late", out_code, 2'b01);
    step(6);
    eret_pulse();
    in_irq = 3'b000;
    step(2);

    // Reset during HOLD with pending source 2, lines held high afterwards
    expect_bk(2'b01, 3'b001, 3'b000);
    in_irq = 3'b001;
    step(2);
    in_irq = 3'b101;
    step(1);
    check("t6_pend_hold", out_pend, 3'b100);
    check("t6_busy_hold", out_busy, 1'b1);
    in_RST = 1'b1;
    step(1);
    check("t6_rst_bk",   out_BK,   1'b0);
    check("t6_rst_code", out_code, 2'b00);
    check("t6_rst_pend", out_pend, 3'b000);
    check("t6_rst_isr",  out_isr,  3'b000);
    check("t6_rst_busy", out_busy, 1'b0);
    in_RST = 1'b0;
    step(8);
    check("t6_held_no_pend", out_pend, 3'b000);
    check("t6_held_no_isr",  out_isr,  3'b000);
    check("t6_held_idle",    out_busy, 1'b0);

    step(4);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
